// File: rtl/decode_pkg.sv
// Shared decode definitions: unit IDs, format one-hots, default widths and
// the sequencer buffer depth.
package decode_pkg;

  localparam int INSTRUCTION_COUNTER_WIDTH = 64;
  localparam int INST_MIN_ID_WIDTH         = 8;
  localparam int PAYLOAD_WIDTH             = 128;
  localparam int DECODE_SEQ_BUFFER_DEPTH   = 2;

  typedef enum logic [3:0] {
    UNIT_ALU,
    UNIT_MUL,
    UNIT_DIV,
    UNIT_LSU,
    UNIT_BRANCH,
    UNIT_SYS,
    UNIT_FPU
  } unit_id_t;

  localparam logic [5:0] FMT_A  = 6'b000001;
  localparam logic [5:0] FMT_B  = 6'b000010;
  localparam logic [5:0] FMT_D  = 6'b000100;
  localparam logic [5:0] FMT_DS = 6'b001000;
  localparam logic [5:0] FMT_X  = 6'b010000;
  localparam logic [5:0] FMT_XO = 6'b100000;

  // Width of a decoder index; kept at least 1 so a single-decoder build still has a port.
  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/decode_result_sequencer_if.sv
// Bundle between the format decoders / issue stage and the result sequencer.
// master drives decoder outputs, flush and backpressure; slave is the sequencer.
interface decode_result_sequencer_if #(
  parameter int numDecoders             = 8,
  parameter int payloadWidth            = 128,
  parameter int instructionCounterWidth = 64
);
  import decode_pkg::*;

  localparam int sourceWidth = src_width(numDecoders);

  logic                                       flush_i;
  logic [instructionCounterWidth-1:0]         flushMajId_i;
  logic [numDecoders-1:0]                     decEnable_i;
  logic [numDecoders-1:0]                     decLast_i;
  logic [numDecoders*instructionCounterWidth-1:0] decMajId_i;
  logic [numDecoders*payloadWidth-1:0]        decPayload_i;
  logic [numDecoders-1:0]                     decStall_o;
  logic                                       stall_i;
  logic                                       enable_o;
  logic [instructionCounterWidth-1:0]         majId_o;
  logic [payloadWidth-1:0]                    payload_o;
  logic [sourceWidth-1:0]                     source_o;
  logic                                       timeout_o;

  modport master (
    output flush_i, flushMajId_i, decEnable_i, decLast_i, decMajId_i, decPayload_i, stall_i,
    input  decStall_o, enable_o, majId_o, payload_o, source_o, timeout_o
  );

  modport slave (
    input  flush_i, flushMajId_i, decEnable_i, decLast_i, decMajId_i, decPayload_i, stall_i,
    output decStall_o, enable_o, majId_o, payload_o, source_o, timeout_o
  );

endinterface

// File: rtl/decode_seq_fifo.sv
// Two-entry holding buffer for one decoder: majId, last flag and payload,
// with registered full/empty flags and a synchronous clear.
module decode_seq_fifo
  import decode_pkg::*;
#(
  parameter int maj_id_width  = INSTRUCTION_COUNTER_WIDTH,
  parameter int payload_width = PAYLOAD_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [maj_id_width-1:0]  push_maj_id,
  input  logic                     push_last,
  input  logic [payload_width-1:0] push_payload,
  output logic [maj_id_width-1:0]  head_maj_id,
  output logic                     head_last,
  output logic [payload_width-1:0] head_payload,
  output logic                     full,
  output logic                     empty
);

  logic [maj_id_width-1:0]  maj_id_mem  [DECODE_SEQ_BUFFER_DEPTH];
  logic                     last_mem    [DECODE_SEQ_BUFFER_DEPTH];
  logic [payload_width-1:0] payload_mem [DECODE_SEQ_BUFFER_DEPTH];

  logic       wr_ptr_reg, rd_ptr_reg;
  logic [1:0] count_reg, count_next;
  logic       full_reg, empty_reg;
  logic       do_push, do_pop;

  // Writes into a full buffer are dropped; the decoder is expected to honour full.
  assign do_push = push && !clear && !full_reg;
  assign do_pop  = pop  && !clear && !empty_reg;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_next = count_reg + 2'd1;
        2'b01:   count_next = count_reg - 2'd1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (clear) begin
        wr_ptr_reg <= 1'b0;
        rd_ptr_reg <= 1'b0;
      end else begin
        if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
        if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_next;
      full_reg  <= (count_next == 2'(DECODE_SEQ_BUFFER_DEPTH));
      empty_reg <= (count_next == 2'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      maj_id_mem[wr_ptr_reg]  <= push_maj_id;
      last_mem[wr_ptr_reg]    <= push_last;
      payload_mem[wr_ptr_reg] <= push_payload;
    end
  end

  assign head_maj_id  = maj_id_mem[rd_ptr_reg];
  assign head_last    = last_mem[rd_ptr_reg];
  assign head_payload = payload_mem[rd_ptr_reg];
  assign full         = full_reg;
  assign empty        = empty_reg;

endmodule

// File: rtl/decode_result_sequencer.sv
// Merges per-decoder buffers back into program order by major ID.
// Optional watchdog enabled by defining DECODE_SEQ_TIMEOUT_EN.
module decode_result_sequencer
  import decode_pkg::*;
#(
  parameter int numDecoders             = 8,
  parameter int payloadWidth            = PAYLOAD_WIDTH,
  parameter int instructionCounterWidth = INSTRUCTION_COUNTER_WIDTH,
  parameter int bufferDepth             = DECODE_SEQ_BUFFER_DEPTH,
  parameter int timeoutCycles           = 255
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  decode_result_sequencer_if.slave    bus
);

  localparam int SW = src_width(numDecoders);
  localparam int IW = instructionCounterWidth;
  localparam int PW = payloadWidth;

  logic [numDecoders-1:0] push, pop, full, empty, match, head_last;
  logic [IW-1:0]          head_maj_id  [numDecoders];
  logic [PW-1:0]          head_payload [numDecoders];

  logic [IW-1:0] expected_id_reg;
  logic          grant_valid;
  logic [SW-1:0] grant_idx;
  logic          advance;

  logic          enable_reg;
  logic [IW-1:0] maj_id_reg;
  logic [PW-1:0] payload_reg;
  logic [SW-1:0] source_reg;

  logic unused_cfg;
  assign unused_cfg = (bufferDepth != DECODE_SEQ_BUFFER_DEPTH);

  assign advance = !bus.flush_i && !bus.stall_i && grant_valid;

  for (genvar gi = 0; gi < numDecoders; gi++) begin : g_dec
    // Decoder 0 occupies the most significant slice of the flattened buses.
    localparam int slot = numDecoders - 1 - gi;

    assign push[gi]  = bus.decEnable_i[gi] && !full[gi] && !bus.flush_i;
    assign pop[gi]   = advance && (grant_idx == SW'(gi));
    assign match[gi] = !empty[gi] && (head_maj_id[gi] == expected_id_reg);

    decode_seq_fifo #(
      .maj_id_width  (IW),
      .payload_width (PW)
    ) u_fifo (
      .clk          (clock_i),
      .rst          (reset_i),
      .clear        (bus.flush_i),
      .push         (push[gi]),
      .pop          (pop[gi]),
      .push_maj_id  (bus.decMajId_i[slot*IW +: IW]),
      .push_last    (bus.decLast_i[gi]),
      .push_payload (bus.decPayload_i[slot*PW +: PW]),
      .head_maj_id  (head_maj_id[gi]),
      .head_last    (head_last[gi]),
      .head_payload (head_payload[gi]),
      .full         (full[gi]),
      .empty        (empty[gi])
    );
  end

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = numDecoders - 1; k >= 0; k--) begin
      if (match[k]) begin
        grant_valid = 1'b1;
        grant_idx   = SW'(k);
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      enable_reg      <= 1'b0;
      maj_id_reg      <= '0;
      payload_reg     <= '0;
      source_reg      <= '0;
      expected_id_reg <= '0;
    end else if (bus.flush_i) begin
      enable_reg      <= 1'b0;
      expected_id_reg <= bus.flushMajId_i;
    end else if (!bus.stall_i) begin
      if (grant_valid) begin
        enable_reg  <= 1'b1;
        maj_id_reg  <= head_maj_id[grant_idx];
        payload_reg <= head_payload[grant_idx];
        source_reg  <= grant_idx;
        if (head_last[grant_idx]) expected_id_reg <= expected_id_reg + IW'(1);
      end else begin
        enable_reg <= 1'b0;
      end
    end
  end

  assign bus.decStall_o = full;
  assign bus.enable_o   = enable_reg;
  assign bus.majId_o    = maj_id_reg;
  assign bus.payload_o  = payload_reg;
  assign bus.source_o   = source_reg;

`ifdef DECODE_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(timeoutCycles + 1);
  localparam logic [TW-1:0] WD_LIMIT = TW'(timeoutCycles);

  logic [TW-1:0] wd_count_reg;
  logic          timeout_reg;
  logic          stuck;

  assign stuck = !bus.stall_i && !grant_valid && !(&empty);

  // Counter saturates at the limit; the flag stays set until reset or flush.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wd_count_reg <= '0;
      timeout_reg  <= 1'b0;
    end else if (bus.flush_i) begin
      wd_count_reg <= '0;
      timeout_reg  <= 1'b0;
    end else if (advance) begin
      wd_count_reg <= '0;
    end else if (stuck && (wd_count_reg != WD_LIMIT)) begin
      wd_count_reg <= wd_count_reg + TW'(1);
      if (wd_count_reg == WD_LIMIT - TW'(1)) timeout_reg <= 1'b1;
    end
  end

  assign bus.timeout_o = timeout_reg;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (timeoutCycles == 0);
  assign bus.timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_decode_result_sequencer.sv
// Directed bench for decode_result_sequencer: ordering, micro-ops,
// backpressure, flush, ID wrap and watchdog (DECODE_SEQ_TIMEOUT_EN aware).
module tb_decode_result_sequencer;

  localparam int N  = 8;
  localparam int PW = 128;
  localparam int IW = 64;
  localparam int TO = 16;
`ifdef DECODE_SEQ_TIMEOUT_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  decode_result_sequencer_if #(
    .numDecoders(N), .payloadWidth(PW), .instructionCounterWidth(IW)
  ) bus ();

  decode_result_sequencer #(
    .numDecoders(N), .payloadWidth(PW), .instructionCounterWidth(IW),
    .bufferDepth(2), .timeoutCycles(TO)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_dec();
    bus.decEnable_i = '0;
    bus.decLast_i   = '0;
  endtask

  task automatic set_dec(input int k, input logic [IW-1:0] id, input logic last,
                         input logic [PW-1:0] pl);
    bus.decEnable_i[k]                = 1'b1;
    bus.decLast_i[k]                  = last;
    bus.decMajId_i[(N-1-k)*IW +: IW]  = id;
    bus.decPayload_i[(N-1-k)*PW +: PW] = pl;
  endtask

  task automatic do_flush(input logic [IW-1:0] id);
    bus.flush_i      = 1'b1;
    bus.flushMajId_i = id;
    step();
    bus.flush_i = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    bus.flush_i      = 1'b0;
    bus.flushMajId_i = '0;
    bus.stall_i      = 1'b0;
    bus.decMajId_i   = '0;
    bus.decPayload_i = '0;
    clear_dec();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check_eq("rst_enable",  bus.enable_o,   0);
    check_eq("rst_majid",   bus.majId_o,    0);
    check_eq("rst_payload", bus.payload_o,  0);
    check_eq("rst_source",  bus.source_o,   0);
    check_eq("rst_timeout", bus.timeout_o,  0);
    check_eq("rst_stall",   bus.decStall_o, 0);

    // Single entry from decoder 3
    set_dec(3, 64'd0, 1'b1, 128'hABC);
    step();
    clear_dec();
    check_eq("single_lat0", bus.enable_o, 0);
    step();
    check_eq("single_en",   bus.enable_o,  1);
    check_eq("single_src",  bus.source_o,  3);
    check_eq("single_maj",  bus.majId_o,   0);
    check_eq("single_pl",   bus.payload_o, 128'hABC);
    step();
    check_eq("single_idle", bus.enable_o, 0);
    check_eq("single_hold", bus.source_o, 3);

    // Reordering: majId 1 arrives before majId 0
    do_flush(64'd0);
    set_dec(1, 64'd1, 1'b1, 128'h11);
    step();
    clear_dec();
    set_dec(0, 64'd0, 1'b1, 128'h10);
    step();
    clear_dec();
    check_eq("reord_wait", bus.enable_o, 0);
    step();
    check_eq("reord_maj0", bus.majId_o,  0);
    check_eq("reord_src0", bus.source_o, 0);
    step();
    check_eq("reord_en1",  bus.enable_o, 1);
    check_eq("reord_maj1", bus.majId_o,  1);
    check_eq("reord_src1", bus.source_o, 1);
    step();
    check_eq("reord_idle", bus.enable_o, 0);

    // Micro-ops: two uops with majId 5, then decoder 4 majId 6
    do_flush(64'd5);
    set_dec(2, 64'd5, 1'b0, 128'hA5);
    set_dec(4, 64'd6, 1'b1, 128'hC6);
    step();
    clear_dec();
    set_dec(2, 64'd5, 1'b1, 128'hB5);
    step();
    clear_dec();
    check_eq("uop1_maj", bus.majId_o,   5);
    check_eq("uop1_src", bus.source_o,  2);
    check_eq("uop1_pl",  bus.payload_o, 128'hA5);
    step();
    check_eq("uop2_maj", bus.majId_o,   5);
    check_eq("uop2_pl",  bus.payload_o, 128'hB5);
    step();
    check_eq("uop3_maj", bus.majId_o,   6);
    check_eq("uop3_src", bus.source_o,  4);
    step();
    check_eq("uop_idle", bus.enable_o, 0);

    // Backpressure: stall 4 cycles while decoder 0 offers majId 0..2
    do_flush(64'd0);
    bus.stall_i = 1'b1;
    set_dec(0, 64'd0, 1'b1, 128'hD0);
    step();
    check_eq("bp_nostall1", bus.decStall_o[0], 0);
    set_dec(0, 64'd1, 1'b1, 128'hD1);
    step();
    check_eq("bp_full", bus.decStall_o[0], 1);
    check_eq("bp_en0",  bus.enable_o, 0);
    set_dec(0, 64'd2, 1'b1, 128'hD2);
    step();
    check_eq("bp_hold_en",  bus.enable_o, 0);
    check_eq("bp_hold_maj", bus.majId_o,  6);
    step();
    check_eq("bp_full2", bus.decStall_o[0], 1);
    bus.stall_i = 1'b0;
    step();
    check_eq("bp_drain0", bus.majId_o, 0);
    check_eq("bp_en1",    bus.enable_o, 1);
    check_eq("bp_unfull", bus.decStall_o[0], 0);
    step();
    clear_dec();
    check_eq("bp_drain1", bus.majId_o, 1);
    step();
    check_eq("bp_drain2", bus.majId_o,   2);
    check_eq("bp_pl2",    bus.payload_o, 128'hD2);
    step();
    check_eq("bp_idle", bus.enable_o, 0);

    // Flush mid-operation with stale majIds 3 and 4 buffered
    bus.stall_i = 1'b1;
    set_dec(5, 64'd3, 1'b1, 128'hE3);
    step();
    set_dec(5, 64'd4, 1'b1, 128'hE4);
    step();
    clear_dec();
    set_dec(2, 64'd100, 1'b1, 128'hBAD);
    do_flush(64'd100);
    bus.stall_i = 1'b0;
    clear_dec();
    check_eq("fl_en",    bus.enable_o,   0);
    check_eq("fl_stall", bus.decStall_o, 0);
    set_dec(7, 64'd100, 1'b1, 128'hF100);
    step();
    clear_dec();
    check_eq("fl_discard", bus.enable_o, 0);
    step();
    check_eq("fl_en100", bus.enable_o,  1);
    check_eq("fl_maj",   bus.majId_o,   100);
    check_eq("fl_src",   bus.source_o,  7);
    step();
    check_eq("fl_nostale", bus.enable_o, 0);

    // Expected ID wraps from all-ones to zero
    do_flush({IW{1'b1}});
    set_dec(3, {IW{1'b1}}, 1'b1, 128'h7F);
    step();
    set_dec(3, 64'd0, 1'b1, 128'h70);
    step();
    clear_dec();
    check_eq("wrap_top", bus.majId_o, {IW{1'b1}});
    step();
    check_eq("wrap_en",   bus.enable_o, 1);
    check_eq("wrap_zero", bus.majId_o,  0);

    // Watchdog: decoder 1 holds majId 7 while expecting 0
    do_flush(64'd0);
    set_dec(1, 64'd7, 1'b1, 128'h77);
    step();
    clear_dec();
    repeat (TO - 1) step();
    check_eq("wd_before", bus.timeout_o, 0);
    step();
    check_eq("wd_fire", bus.timeout_o, WD_ON);
    repeat (3) step();
    check_eq("wd_sticky", bus.timeout_o, WD_ON);
    do_flush(64'd0);
    check_eq("wd_clear", bus.timeout_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
